// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | game_pkg                                                                     |
// | Shared game constants and FSM state encoding (collision, score, HUD).      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
package game_pkg;

    localparam int COORD_W     = 9;
    localparam int START_LIVES = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        HIT_WAIT = 2'd2,
        OVER     = 2'd3
    } state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/monster_collision_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | monster_collision_if                                                         |
// | Positions/strobes into the collision block and game status out of it.      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
interface monster_collision_if #(
    parameter int NUM_MON = 3,
    parameter int COORD_W = game_pkg::COORD_W
);
    logic                       game_tick;
    logic                       start;
    logic [COORD_W-1:0]         p_x;
    logic [COORD_W-1:0]         p_y;
    logic [NUM_MON*COORD_W-1:0] m_x_flat;
    logic [NUM_MON*COORD_W-1:0] m_y_flat;
    logic [1:0]                 lives;
    logic                       hit;
    logic                       respawn;
    logic                       invuln;
    logic                       game_over;
    logic [1:0]                 state;

    modport master (
        output game_tick, start, p_x, p_y, m_x_flat, m_y_flat,
        input  lives, hit, respawn, invuln, game_over, state
    );

    modport slave (
        input  game_tick, start, p_x, p_y, m_x_flat, m_y_flat,
        output lives, hit, respawn, invuln, game_over, state
    );
endinterface : monster_collision_if
`default_nettype wire

// File: rtl/box_overlap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | box_overlap                                                                  |
// | Combinational per-axis |difference| < HIT_RADIUS test for one monster.     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module box_overlap #(
    parameter int COORD_W    = game_pkg::COORD_W,
    parameter int HIT_RADIUS = 8
) (
    input  wire logic [COORD_W-1:0] i_p_x,
    input  wire logic [COORD_W-1:0] i_p_y,
    input  wire logic [COORD_W-1:0] i_m_x,
    input  wire logic [COORD_W-1:0] i_m_y,
    output logic                    o_contact
);
    localparam logic [COORD_W:0] c_radius = (COORD_W+1)'(HIT_RADIUS);

    logic signed [COORD_W:0] w_dx;
    logic signed [COORD_W:0] w_dy;
    logic        [COORD_W:0] w_adx;
    logic        [COORD_W:0] w_ady;

    // One extra bit keeps 0 vs max-coordinate from wrapping into a small difference.
    always_comb begin
        w_dx      = $signed({1'b0, i_p_x}) - $signed({1'b0, i_m_x});
        w_dy      = $signed({1'b0, i_p_y}) - $signed({1'b0, i_m_y});
        w_adx     = w_dx[COORD_W] ? $unsigned(-w_dx) : $unsigned(w_dx);
        w_ady     = w_dy[COORD_W] ? $unsigned(-w_dy) : $unsigned(w_dy);
        o_contact = (w_adx < c_radius) && (w_ady < c_radius);
    end
endmodule : box_overlap
`default_nettype wire

// File: rtl/monster_collision.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | monster_collision                                                            |
// | Player/monster contact detection, lives, invulnerability and game-over.    |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module monster_collision #(
    parameter int NUM_MON      = 3,
    parameter int COORD_W      = game_pkg::COORD_W,
    parameter int HIT_RADIUS   = 8,
    parameter int START_LIVES  = game_pkg::START_LIVES,
    parameter int INVULN_TICKS = 120
) (
    input  wire logic          clk_50mhz,
    input  wire logic          rst,
    monster_collision_if.slave bus
);
    import game_pkg::*;

    localparam int CNT_W = (INVULN_TICKS > 0) ? $clog2(INVULN_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] c_invuln      = CNT_W'(INVULN_TICKS);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [1:0]       c_start_lives = 2'(START_LIVES);

    if (INVULN_TICKS < 1) begin : g_chk_invuln
        $error("monster_collision: INVULN_TICKS must be at least 1");
    end
    if (START_LIVES < 1 || START_LIVES > 3) begin : g_chk_lives
        $error("monster_collision: START_LIVES must be in 1..3");
    end

    logic [NUM_MON-1:0] w_contact;

    for (genvar i = 0; i < NUM_MON; i++) begin : g_mon
        box_overlap #(
            .COORD_W   (COORD_W),
            .HIT_RADIUS(HIT_RADIUS)
        ) u_box (
            .i_p_x    (bus.p_x),
            .i_p_y    (bus.p_y),
            .i_m_x    (bus.m_x_flat[i*COORD_W +: COORD_W]),
            .i_m_y    (bus.m_y_flat[i*COORD_W +: COORD_W]),
            .o_contact(w_contact[i])
        );
    end

    state_t             state_q,     state_d;
    logic [1:0]         lives_q,     lives_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               hit_q,       hit_d;
    logic               respawn_q,   respawn_d;
    logic               invuln_q,    invuln_d;
    logic               game_over_q, game_over_d;
    logic               valid_q,     valid_d;
    logic [NUM_MON-1:0] contact_q,   contact_d;

    always_comb begin
        valid_d     = bus.game_tick;
        contact_d   = bus.game_tick ? w_contact : '0;
        state_d     = state_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        hit_d       = 1'b0;
        respawn_d   = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d   = PLAY;
                    lives_d   = c_start_lives;
                    respawn_d = 1'b1;
                end
            end
            PLAY: begin
                // Several simultaneous contacts still cost a single life.
                if (valid_q && |contact_q) begin
                    hit_d = 1'b1;
                    if (lives_q > 2'd1) begin
                        state_d   = HIT_WAIT;
                        lives_d   = lives_q - 2'd1;
                        respawn_d = 1'b1;
                        cnt_d     = c_invuln;
                    end else begin
                        state_d = OVER;
                        lives_d = 2'd0;
                    end
                end
            end
            HIT_WAIT: begin
                if (valid_q) begin
                    if (cnt_q == c_cnt_one) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - c_cnt_one;
                    end
                end
            end
        endcase

        invuln_d    = (state_d == HIT_WAIT);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q     <= IDLE;
            lives_q     <= 2'd0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            respawn_q   <= 1'b0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
            valid_q     <= 1'b0;
            contact_q   <= '0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            respawn_q   <= respawn_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
            valid_q     <= valid_d;
            contact_q   <= contact_d;
        end
    end

    assign bus.lives     = lives_q;
    assign bus.hit       = hit_q;
    assign bus.respawn   = respawn_q;
    assign bus.invuln    = invuln_q;
    assign bus.game_over = game_over_q;
    assign bus.state     = state_q;
endmodule : monster_collision
`default_nettype wire

// File: tb/tb_monster_collision.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_monster_collision                                                         |
// | Scenario tasks plus randomized play against a game-rule reference model.   |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_monster_collision;
    import game_pkg::*;

    localparam int NM = 3;
    localparam int CW = 9;
    localparam int HR = 8;
    localparam int SL = 3;
    localparam int IT = 120;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    monster_collision_if #(.NUM_MON(NM), .COORD_W(CW)) bus ();

    monster_collision #(
        .NUM_MON(NM), .COORD_W(CW), .HIT_RADIUS(HR),
        .START_LIVES(SL), .INVULN_TICKS(IT)
    ) dut (
        .clk_50mhz(clk),
        .rst      (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: game mode, lives, remaining invulnerable ticks.
    int m_state, m_lives, m_cnt;
    int px, py;
    int mx[NM];
    int my[NM];
    logic [5:0] tick_obs;   // {hit@+0,+1,+2, respawn@+0,+1,+2} relative to sampling edge
    logic [1:0] start_obs;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit model_contact();
        for (int i = 0; i < NM; i++)
            if (iabs(px - mx[i]) < HR && iabs(py - my[i]) < HR) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_tick(output bit eh, output bit er);
        bit c;
        c  = model_contact();
        eh = 1'b0;
        er = 1'b0;
        if (m_state == 1 && c) begin
            eh = 1'b1;
            if (m_lives > 1) begin
                m_lives = m_lives - 1; m_state = 2; m_cnt = IT; er = 1'b1;
            end else begin
                m_lives = 0; m_state = 3;
            end
        end else if (m_state == 2) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_state = 1;
        end
    endtask

    task automatic drive_pos();
        bus.p_x = CW'(px);
        bus.p_y = CW'(py);
        for (int i = 0; i < NM; i++) begin
            bus.m_x_flat[i*CW +: CW] = CW'(mx[i]);
            bus.m_y_flat[i*CW +: CW] = CW'(my[i]);
        end
    endtask

    task automatic set_far();
        px = 50; py = 50;
        mx[0] = 300; my[0] = 300;
        mx[1] = 400; my[1] = 100;
        mx[2] = 200; my[2] = 450;
    endtask

    task automatic do_tick(output bit eh, output bit er);
        model_tick(eh, er);
        @(posedge clk); #1;
        drive_pos();
        bus.game_tick = 1'b1;
        @(posedge clk); #1;
        bus.game_tick = 1'b0;
        tick_obs[5] = bus.hit; tick_obs[2] = bus.respawn;
        @(posedge clk); #1;
        tick_obs[4] = bus.hit; tick_obs[1] = bus.respawn;
        @(posedge clk); #1;
        tick_obs[3] = bus.hit; tick_obs[0] = bus.respawn;
    endtask

    task automatic do_start(output bit er);
        er = (m_state == 0 || m_state == 3);
        if (er) begin m_state = 1; m_lives = SL; end
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        start_obs[1] = bus.respawn;
        @(posedge clk); #1;
        start_obs[0] = bus.respawn;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = 0; m_lives = 0; m_cnt = 0;
        total++;
        if ({bus.lives, bus.state} !== 4'b0000) begin
            bad++; $display("FAIL reset_lives_state: got %b want 0000", {bus.lives, bus.state});
        end
        total++;
        if ({bus.hit, bus.respawn, bus.invuln, bus.game_over} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000",
                            {bus.hit, bus.respawn, bus.invuln, bus.game_over});
        end
    endtask

    task automatic test_start_play();
        bit eh, er;
        int hits = 0;
        do_start(er);
        total++;
        if (start_obs !== 2'b10) begin
            bad++; $display("FAIL start_respawn: got %b want 10", start_obs);
        end
        set_far();
        for (int k = 0; k < 10; k++) begin
            do_tick(eh, er);
            hits += int'(tick_obs[5]) + int'(tick_obs[4]) + int'(tick_obs[3]);
            hits += int'(tick_obs[2]) + int'(tick_obs[1]) + int'(tick_obs[0]);
        end
        total++;
        if (hits != 0) begin bad++; $display("FAIL far_ticks_pulses: got %0d want 0", hits); end
        total++;
        if ({bus.lives, bus.state} !== {2'd3, 2'd1}) begin
            bad++; $display("FAIL far_lives_state: got %b want 1101", {bus.lives, bus.state});
        end
    endtask

    task automatic test_hit();
        bit eh, er;
        set_far();
        px = 100; py = 30; mx[2] = 105; my[2] = 30;
        do_tick(eh, er);
        total++;
        if (tick_obs !== 6'b010_010) begin
            bad++; $display("FAIL hit_timing: got %b want 010010", tick_obs);
        end
        total++;
        if ({bus.lives, bus.invuln, bus.state} !== {2'd2, 1'b1, 2'd2}) begin
            bad++; $display("FAIL hit_status: got %b want 10110", {bus.lives, bus.invuln, bus.state});
        end
    endtask

    task automatic test_invuln();
        bit eh, er;
        int hits = 0;
        for (int k = 0; k < IT - 1; k++) begin
            do_tick(eh, er);
            hits += int'(tick_obs[4]);
        end
        total++;
        if (hits != 0 || bus.lives !== 2'd2 || bus.state !== 2'd2) begin
            bad++; $display("FAIL invuln_hold: got hits=%0d lives=%0d state=%0d want 0 2 2",
                            hits, bus.lives, bus.state);
        end
        do_tick(eh, er);
        total++;
        if ({bus.state, bus.invuln, tick_obs[4]} !== {2'd1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL invuln_expire: got %b want 0100", {bus.state, bus.invuln, tick_obs[4]});
        end
        do_tick(eh, er);
        total++;
        if (tick_obs !== {1'b0, eh, 2'b00, er, 1'b0} || bus.lives !== 2'd1) begin
            bad++; $display("FAIL second_hit: got pulses=%b lives=%0d want 010010 1", tick_obs, bus.lives);
        end
        set_far();
        while (m_state == 2) do_tick(eh, er);
        total++;
        if (bus.state !== 2'(m_state)) begin
            bad++; $display("FAIL leave_hitwait: got %0d want %0d", bus.state, m_state);
        end
    endtask

    task automatic test_boundary_game_over();
        bit eh, er;
        set_far();
        px = 0; py = 100; mx[0] = 511; my[0] = 100;
        do_tick(eh, er);
        total++;
        if (tick_obs !== 6'b0 || bus.lives !== 2'd1) begin
            bad++; $display("FAIL no_wrap_0_511: got pulses=%b lives=%0d want 000000 1", tick_obs, bus.lives);
        end
        px = 10; mx[0] = 2;
        do_tick(eh, er);
        total++;
        if (tick_obs !== 6'b0 || bus.state !== 2'd1) begin
            bad++; $display("FAIL dx_eq_radius: got pulses=%b state=%0d want 000000 1", tick_obs, bus.state);
        end
        mx[0] = 3;
        do_tick(eh, er);
        total++;
        if (tick_obs !== 6'b010_000) begin
            bad++; $display("FAIL last_life_hit: got %b want 010000", tick_obs);
        end
        total++;
        if ({bus.state, bus.game_over, bus.lives, bus.invuln} !== {2'd3, 1'b1, 2'd0, 1'b0}) begin
            bad++; $display("FAIL game_over_status: got %b want 111000",
                            {bus.state, bus.game_over, bus.lives, bus.invuln});
        end
    endtask

    task automatic test_restart();
        bit er;
        do_start(er);
        total++;
        if ({start_obs, bus.lives, bus.state, bus.game_over} !== {2'b10, 2'd3, 2'd1, 1'b0}) begin
            bad++; $display("FAIL restart: got %b want 1011010",
                            {start_obs, bus.lives, bus.state, bus.game_over});
        end
        do_start(er);
        total++;
        if ({start_obs, bus.lives, bus.state} !== {2'b00, 2'd3, 2'd1}) begin
            bad++; $display("FAIL start_ignored_in_play: got %b want 001101", {start_obs, bus.lives, bus.state});
        end
    endtask

    task automatic test_multi();
        bit eh, er;
        px = 200; py = 200;
        mx[0] = 200; my[0] = 200;
        mx[1] = 205; my[1] = 195;
        mx[2] = 195; my[2] = 206;
        do_tick(eh, er);
        total++;
        if (tick_obs !== 6'b010_010 || bus.lives !== 2'd2) begin
            bad++; $display("FAIL multi_contact: got pulses=%b lives=%0d want 010010 2", tick_obs, bus.lives);
        end
    endtask

    task automatic test_rst_mid_hitwait();
        @(posedge clk); #1;
        bus.game_tick = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.game_tick = 1'b0;
        rst = 1'b0;
        m_state = 0; m_lives = 0; m_cnt = 0;
        total++;
        if ({bus.lives, bus.state, bus.hit, bus.respawn, bus.invuln, bus.game_over} !== 8'b0) begin
            bad++; $display("FAIL rst_mid_hitwait: got %b want 00000000",
                            {bus.lives, bus.state, bus.hit, bus.respawn, bus.invuln, bus.game_over});
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.state, bus.hit, bus.respawn} !== 4'b0) begin
            bad++; $display("FAIL rst_pending_discard: got %b want 0000", {bus.state, bus.hit, bus.respawn});
        end
    endtask

    task automatic test_back_to_back();
        bit er, e1, r1, e2, r2;
        logic [3:0] h;
        do_start(er);
        set_far();
        px = 300; py = 300; mx[0] = 302; my[0] = 300;
        model_tick(e1, r1);
        model_tick(e2, r2);
        @(posedge clk); #1;
        drive_pos();
        bus.game_tick = 1'b1;
        @(posedge clk); #1;
        h[3] = bus.hit;
        @(posedge clk); #1;
        bus.game_tick = 1'b0;
        h[2] = bus.hit;
        @(posedge clk); #1;
        h[1] = bus.hit;
        @(posedge clk); #1;
        h[0] = bus.hit;
        total++;
        if (h !== {1'b0, e1, e2, 1'b0} || bus.lives !== 2'(m_lives) || bus.state !== 2'(m_state)) begin
            bad++; $display("FAIL back_to_back: got hits=%b lives=%0d state=%0d want %b %0d %0d",
                            h, bus.lives, bus.state, {1'b0, e1, e2, 1'b0}, m_lives, m_state);
        end
    endtask

    task automatic test_random();
        bit eh, er;
        int errs = 0;
        for (int n = 0; n < 300; n++) begin
            if ((m_state == 0 || m_state == 3) ? ($urandom_range(0, 2) == 0)
                                               : ($urandom_range(0, 19) == 0)) begin
                do_start(er);
                total++;
                if (start_obs !== {er, 1'b0} || bus.state !== 2'(m_state)) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rand_start: got resp=%b state=%0d want %b %0d",
                                            start_obs, bus.state, {er, 1'b0}, m_state);
                end
            end
            px = int'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) px = ($urandom_range(0, 1) == 1) ? 511 : 0;
            py = int'($urandom_range(0, 511));
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    mx[i] = int'($urandom_range(0, 511));
                    my[i] = int'($urandom_range(0, 511));
                end else begin
                    mx[i] = px + int'($urandom_range(0, 20)) - 10;
                    my[i] = py + int'($urandom_range(0, 20)) - 10;
                    mx[i] = (mx[i] < 0) ? 0 : (mx[i] > 511) ? 511 : mx[i];
                    my[i] = (my[i] < 0) ? 0 : (my[i] > 511) ? 511 : my[i];
                end
            end
            do_tick(eh, er);
            total++;
            if (tick_obs !== {1'b0, eh, 2'b00, er, 1'b0} || bus.lives !== 2'(m_lives) ||
                bus.state !== 2'(m_state) || bus.invuln !== (m_state == 2) ||
                bus.game_over !== (m_state == 3)) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_tick %0d: got pulses=%b lives=%0d state=%0d want %b %0d %0d",
                                        n, tick_obs, bus.lives, bus.state,
                                        {1'b0, eh, 2'b00, er, 1'b0}, m_lives, m_state);
            end
        end
    endtask

    initial begin
        bus.game_tick = 1'b0;
        bus.start     = 1'b0;
        bus.p_x       = '0;
        bus.p_y       = '0;
        bus.m_x_flat  = '0;
        bus.m_y_flat  = '0;
        tick_obs      = '0;
        start_obs     = '0;
        test_reset();
        test_start_play();
        test_hit();
        test_invuln();
        test_boundary_game_over();
        test_restart();
        test_multi();
        test_rst_mid_hitwait();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule : tb_monster_collision
`default_nettype wire

// File: doc/monster_collision.md
Name: monster_collision

Overview:
- Consumes the per-monster positions (m_x/m_y) from the monster instances and the player position (p_x/p_y).
- Detects player–monster contact on each game movement tick and manages lives, post-hit invulnerability, respawn requests and game-over.
- Sits directly downstream of the monster movement blocks. Its respawn strobe is consumed by the player and monster position logic.

Parameters:
- NUM_MON, 3, number of monster position inputs.
- COORD_W, 9, coordinate width in bits, matching p_x/m_x.
- HIT_RADIUS, 8, contact threshold in pixels per axis; contact when |dx| < HIT_RADIUS and |dy| < HIT_RADIUS.
- START_LIVES, 3, lives loaded on start; must be ≤ 3.
- INVULN_TICKS, 120, game ticks of invulnerability after a hit.

Ports:
- clk_50mhz  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- game_tick  in  1  one-cycle strobe, once per movement step (aligned to the slow move clock).
- start  in  1  level; starts or restarts a game from IDLE or OVER.
- p_x, p_y  in  COORD_W each  player position.
- m_x_flat, m_y_flat  in  NUM_MON*COORD_W each  monster positions; monster i occupies bits [i*COORD_W +: COORD_W].
- lives  out  2  remaining lives.
- hit  out  1  one-cycle pulse when a life is lost.
- respawn  out  1  one-cycle pulse; all positions must reload their start values.
- invuln  out  1  high while in HIT_WAIT.
- game_over  out  1  high in OVER.
- state  out  2  current FSM state, for debug/HUD.

Behaviour:
- Reset values: state=IDLE, lives=0, hit=0, respawn=0, invuln=0, game_over=0, tick counter=0, stage-1 registers cleared.
- Stage 1, on the game_tick cycle:
  - Per monster, dx = {1'b0,p_x} − {1'b0,m_x}, computed as COORD_W+1 signed; same for dy.
  - Take the absolute value of each, compare against HIT_RADIUS, AND the two axes.
  - Register the NUM_MON-bit contact vector plus a valid bit (valid = the tick).
- Stage 2: FSM acts on the valid bit the following cycle. hit/respawn assert exactly 2 cycles after the game_tick edge.
- Contact vector is OR-reduced. Any number of simultaneous contacts costs exactly one life.
- FSM transitions:
  - IDLE: start=1 → PLAY. lives←START_LIVES, respawn pulse.
  - PLAY: valid && contact && lives>1 → HIT_WAIT. lives−1, hit pulse, respawn pulse, counter←INVULN_TICKS.
  - PLAY: valid && contact && lives==1 → OVER. lives←0, hit pulse, no respawn.
  - HIT_WAIT: contacts ignored; counter decrements on each valid. At counter==1 with valid → PLAY, counter←0.
  - OVER: game_over=1. start=1 → PLAY, lives←START_LIVES, respawn pulse.
- start is ignored in PLAY and HIT_WAIT.
- Boundaries:
  - Coordinates at 0 or 511 must not wrap the difference; the 10-bit signed subtraction is mandatory.
  - |dx| == HIT_RADIUS is not contact.
  - lives never underflows below 0.
  - A game_tick arriving in the same cycle as a stage-2 decision is sampled normally. The next decision sees the post-transition state.
  - rst asserted in any state, including mid-HIT_WAIT, returns everything to reset values on the next edge; a pending stage-1 valid is discarded.
  - INVULN_TICKS=0 is illegal; a static check is required.

Decomposition:
- Shared package (game_pkg): COORD_W, state encodings IDLE=0, PLAY=1, HIT_WAIT=2, OVER=3, and START_LIVES, shared with the score/HUD logic.
- One sub-module, box_overlap: combinational abs-difference compare for a single monster, instantiated NUM_MON times in a generate loop.
- FSM and counter stay in the top module.

Test Plan:
- rst, then start=1 with player (50,50) and monsters far away, 10 ticks → lives=3, respawn one pulse, hit never asserts, state=PLAY.
- Player (100,30), monster 2 at (105,30), one game_tick → hit and respawn pulse 2 cycles later, lives=2, invuln=1, state=HIT_WAIT.
- Keep overlap during HIT_WAIT for 119 ticks → no further hit, lives=2. Tick 120 → state=PLAY. Next tick with overlap → lives=1.
- All three monsters overlapping the player on the same tick → exactly one hit pulse, lives decrements by 1.
- Axis boundary checks:
  - p_x=0 with m_x=511 → no contact (no wrap).
  - p_x=10 with m_x=2 (|dx|=8) → no contact.
  - p_x=10 with m_x=3 → contact.
- lives=1 with contact → state=OVER, game_over=1, lives=0, no respawn. start=1 → PLAY, lives=3. rst asserted mid-HIT_WAIT → all outputs reset next cycle.
